// File: rtl/hwag_coil_sched_if.sv
// Bundle of angle-base, shadow-write, dwell and coil-drive signals for the
// four-channel coil scheduler.
interface hwag_coil_sched_if #(
    parameter int W  = 24,
    parameter int DW = 16
);
    logic          ena;
    logic [W-1:0]  angle;
    logic [3:0]    ch_en;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic          wr_sel;
    logic [W-1:0]  wr_data;
    logic [DW-1:0] max_dwell;
    logic [3:0]    fault_clr;
    logic [3:0]    out;
    logic [3:0]    fault;

    modport master (
        output ena, angle, ch_en, wr_en, wr_ch, wr_sel, wr_data, max_dwell, fault_clr,
        input  out, fault
    );

    modport slave (
        input  ena, angle, ch_en, wr_en, wr_ch, wr_sel, wr_data, max_dwell, fault_clr,
        output out, fault
    );
endinterface

// File: rtl/hwag_coil_sched.sv
// Four-channel angle-window coil scheduler: one shared window comparator
// served round-robin, per-channel FSM, dwell timeout with sticky fault.
//
// state | meaning
// IDLE  | channel disabled or angle base invalid, coil off
// SYNC  | active window loaded, waiting for angle to be outside it
// ARMED | outside the window, waiting for the window to open
// ON    | coil driven, dwell counter running
module hwag_coil_sched #(
    parameter int W  = 24,
    parameter int DW = 16
) (
    input logic clk,
    input logic rst,
    hwag_coil_sched_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SYNC, ARMED, ON} state_t;

    state_t        state   [4];
    logic [W-1:0]  sh_on   [4];
    logic [W-1:0]  sh_off  [4];
    logic [W-1:0]  act_on  [4];
    logic [W-1:0]  act_off [4];
    logic [W-1:0]  ld_on   [4];
    logic [W-1:0]  ld_off  [4];
    logic [DW-1:0] dwell   [4];
    logic [DW-1:0] dwell_inc [4];
    logic [3:0]    timeout;
    logic [3:0]    fault_set;
    logic [3:0]    sel;
    logic [1:0]    ptr;
    logic [3:0]    out_q;
    logic [3:0]    fault_q;
    logic [W-1:0]  cmp_on;
    logic [W-1:0]  cmp_off;
    logic          in_win;

    assign sel = bus.ena ? (4'b0001 << ptr) : 4'b0000;

    // Shared comparator: only the channel under the pointer is evaluated.
    always_comb begin
        cmp_on  = act_on[ptr];
        cmp_off = act_off[ptr];
        if (cmp_on < cmp_off)
            in_win = (bus.angle >= cmp_on) && (bus.angle < cmp_off);
        else if (cmp_on > cmp_off)
            in_win = (bus.angle >= cmp_on) || (bus.angle < cmp_off);
        else
            in_win = 1'b0;
    end

    // A write landing on the same edge as a SYNC entry goes straight to the active copy.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ld_on[i]  = sh_on[i];
            ld_off[i] = sh_off[i];
            if (bus.wr_en && (bus.wr_ch == 2'(i))) begin
                if (bus.wr_sel)
                    ld_off[i] = bus.wr_data;
                else
                    ld_on[i]  = bus.wr_data;
            end
            dwell_inc[i] = (&dwell[i]) ? dwell[i] : dwell[i] + DW'(1);
            timeout[i]   = (bus.max_dwell != '0) && (dwell_inc[i] >= bus.max_dwell);
            fault_set[i] = bus.ena && bus.ch_en[i] && (state[i] == ON) && timeout[i]
                           && !(sel[i] && !in_win);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sh_on[i]  <= '0;
                sh_off[i] <= '0;
            end
        end else if (bus.wr_en) begin
            if (bus.wr_sel)
                sh_off[bus.wr_ch] <= bus.wr_data;
            else
                sh_on[bus.wr_ch]  <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            out_q   <= '0;
            fault_q <= '0;
            for (int i = 0; i < 4; i++) begin
                state[i]   <= IDLE;
                dwell[i]   <= '0;
                act_on[i]  <= '0;
                act_off[i] <= '0;
            end
        end else begin
            if (bus.ena)
                ptr <= ptr + 2'd1;
            fault_q <= (fault_q & ~bus.fault_clr) | fault_set;
            for (int i = 0; i < 4; i++) begin
                if (!bus.ena || !bus.ch_en[i]) begin
                    state[i] <= IDLE;
                    out_q[i] <= 1'b0;
                end else begin
                    case (state[i])
                        IDLE: begin
                            if (sel[i]) begin
                                state[i]   <= SYNC;
                                act_on[i]  <= ld_on[i];
                                act_off[i] <= ld_off[i];
                            end
                        end
                        SYNC: begin
                            if (sel[i] && !in_win)
                                state[i] <= ARMED;
                        end
                        ARMED: begin
                            if (sel[i] && in_win) begin
                                state[i] <= ON;
                                out_q[i] <= 1'b1;
                                dwell[i] <= '0;
                            end
                        end
                        ON: begin
                            dwell[i] <= dwell_inc[i];
                            // Normal end and timeout both re-sync; the timeout is
                            // not restricted to the selected cycle.
                            if ((sel[i] && !in_win) || timeout[i]) begin
                                state[i]   <= SYNC;
                                out_q[i]   <= 1'b0;
                                act_on[i]  <= ld_on[i];
                                act_off[i] <= ld_off[i];
                            end
                        end
                        default: begin
                            state[i] <= IDLE;
                            out_q[i] <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.out   = out_q;
    assign bus.fault = fault_q;

endmodule

// File: doc/hwag_coil_sched.md
HWAG_COIL_SCHED -- requirements
Module: hwag_coil_sched

Interface
REQ-001 The block SHALL have parameter W, default 24, giving the angle width.
REQ-002 The block SHALL have parameter DW, default 16, giving the dwell-timer width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port ena, input, 1 bit: angle base valid (driven from hwag_start).
REQ-006 The block SHALL have port angle, input, W bits: current crank angle (ACNT2 output).
REQ-007 The block SHALL have port ch_en, input, 4 bits: per-channel enable.
REQ-008 The block SHALL have port wr_en, input, 1 bit: shadow-register write strobe.
REQ-009 The block SHALL have port wr_ch, input, 2 bits: target channel.
REQ-010 The block SHALL have port wr_sel, input, 1 bit: 0 = on-angle, 1 = off-angle.
REQ-011 The block SHALL have port wr_data, input, W bits: write data.
REQ-012 The block SHALL have port max_dwell, input, DW bits: dwell timeout in clk cycles, shared by all channels.
REQ-013 The block SHALL have port fault_clr, input, 4 bits: per-channel fault clear pulse.
REQ-014 The block SHALL have port out, output, 4 bits: coil drive, registered.
REQ-015 The block SHALL have port fault, output, 4 bits: sticky dwell-timeout flags.

Function
REQ-016 Each channel SHALL hold shadow on/off registers, written when wr_en=1 to channel wr_ch and register wr_sel; the shadow values SHALL take effect only via the active copy (REQ-021).
REQ-017 One shared window comparator SHALL serve the channels round-robin.
- A 2-bit pointer advances by one every cycle while ena=1, wrapping 3->0.
- Each channel is therefore evaluated once per 4 cycles.
REQ-018 The window test SHALL be:
- if on<off: in_win = (angle>=on) && (angle<off);
- if on>off (wrap-around): in_win = (angle>=on) || (angle<off);
- if on==off: in_win = 0.
All compares are unsigned, W bits.
REQ-019 Each channel SHALL implement a state machine with states IDLE, SYNC, ARMED and ON.
REQ-020 All state transitions except REQ-025 SHALL occur only on the cycle the channel is selected by the pointer.
REQ-021 IDLE -> SYNC SHALL occur when ena & ch_en[i]; on entry to SYNC, the shadow on/off SHALL be copied to the active on/off.
REQ-022 SYNC -> ARMED SHALL occur when in_win=0, so a channel enabled mid-window never produces a partial pulse.
REQ-023 ARMED -> ON SHALL occur when in_win=1; out[i] SHALL go 1 on the following cycle and the dwell counter SHALL clear to 0.
REQ-024 In ON, the dwell counter SHALL increment every cycle, saturating at all-ones.
- ON -> SYNC when the channel is evaluated with in_win=0 (normal end).
- ON -> SYNC with fault[i] set when the counter reaches max_dwell; this is checked every cycle, not only when selected.
- If both occur in the same cycle, fault SHALL NOT be set.
- max_dwell=0 SHALL disable the timeout.
REQ-025 Any state SHALL go to IDLE within 1 cycle when ena=0 or ch_en[i]=0, with out[i]=0 registered on that same edge.
REQ-026 out[i] SHALL be 1 only in state ON.
REQ-027 fault[i] SHALL stay set until fault_clr[i]=1; if set and clear coincide, set SHALL win.
REQ-028 A shadow write coinciding with entry to SYNC SHALL load the new write data into the active copy.
REQ-029 Latency from angle entering/leaving the window to out change SHALL be 1..5 cycles; ACNT2 steps at most once per 2 cycles, so window widths >=3 counts SHALL never be missed.

Reset
REQ-030 On rst=1, asynchronously and without a clock:
- all channel states SHALL be IDLE;
- pointer, dwell counters and shadow/active on/off registers SHALL be 0;
- out SHALL be 4'b0 and fault SHALL be 4'b0.
REQ-031 Reset asserted mid-pulse SHALL drop out immediately; after release, each channel SHALL pass through SYNC before it can fire again.

Verification
REQ-032 Basic window: ch0 on=100, off=140; sweep angle 0..255 stepping every 2 cycles -> exactly one out[0] pulse, rising 1..5 cycles after angle=100 and falling 1..5 cycles after angle=140.
REQ-033 Wrap-around: ch1 on=250, off=10, top=255 -> pulse spans the angle wrap; on=off=50 -> out[1] never asserts.
REQ-034 Mid-window enable: set ch_en[2]=1 at angle=120 with window 100..140 -> no pulse until the next revolution.
REQ-035 Dwell timeout: max_dwell=20 with angle held at 110 inside window 100..140 -> out[0] high for 20 cycles, fault[0]=1, no re-fire until angle leaves then re-enters the window; fault_clr[0] -> fault[0]=0.
REQ-036 Shadow write while ON: change ch0 off 140->200 at angle 120 -> the current pulse still ends at 140 and the next revolution ends at 200.
REQ-037 Abort: drop ena or assert rst during a pulse -> out=0 within 1 cycle (rst: immediately), and all channels IDLE.
